// File: rtl/cnt_pkg.sv
// Shared definitions for the counter sequencer: default count width and FSM state encodings.
package cnt_pkg;

  localparam int CNT_BIT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/upcnt_ce.sv
// W-bit binary up counter with synchronous clear and count enable.
module upcnt_ce #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ce,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) q_d = '0;
    else if (ce) q_d = q_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Start/pause/resume/clear sequencer for a binary up counter with terminal count and done pulse.
// Optional build macro CNT_SEQ_AUTO_RELOAD_EN: wrap to 0 at terminal and keep running.
module cnt_seq_ctrl #(
  parameter int CNT_BIT_WIDTH = cnt_pkg::CNT_BIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     clear,
  input  logic [CNT_BIT_WIDTH-1:0] tc_val,
  output logic [CNT_BIT_WIDTH-1:0] q,
  output logic                     busy,
  output logic                     paused,
  output logic                     done,
  output logic [1:0]               state
);

  import cnt_pkg::*;

  logic [1:0]               state_q, state_d;
  logic [CNT_BIT_WIDTH-1:0] tc_lat_q, tc_lat_d;
  logic                     done_q, done_d;
  logic                     cnt_clr, cnt_ce;
  logic [CNT_BIT_WIDTH-1:0] cnt_q;

  upcnt_ce #(.W(CNT_BIT_WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .ce  (cnt_ce),
    .q   (cnt_q)
  );

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    tc_lat_d = tc_lat_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_ce   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_RUN;
            tc_lat_d = tc_val;
            cnt_clr  = 1'b1;
          end
        end
        ST_RUN: begin
          // Terminal compare takes precedence over a pause in the same cycle.
          if (cnt_q == tc_lat_q) begin
            done_d = 1'b1;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
            cnt_clr = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            cnt_ce = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start) begin
            state_d  = ST_RUN;
            tc_lat_d = tc_val;
            cnt_clr  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tc_lat_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_lat_q <= tc_lat_d;
      done_q   <= done_d;
    end
  end

  assign q      = cnt_q;
  assign state  = state_q;
  assign busy   = (state_q == ST_RUN);
  assign paused = (state_q == ST_PAUSE);
  assign done   = done_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed sequences plus randomized control against a reference model.
module tb_cnt_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, pause, clear;
  logic [W-1:0] tc_val;
  logic [W-1:0] q;
  logic         busy, paused, done;
  logic [1:0]   state;

  cnt_seq_ctrl #(.CNT_BIT_WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .clear  (clear),
    .tc_val (tc_val),
    .q      (q),
    .busy   (busy),
    .paused (paused),
    .done   (done),
    .state  (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: mode 0 idle, 1 counting, 2 held, 3 finished.
  int m_mode, m_q, m_tc, m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    m_done = 0;
    if (rst) begin
      m_mode = 0; m_q = 0; m_tc = 0;
    end else if (clear) begin
      m_mode = 0; m_q = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_q = 0; m_tc = int'(tc_val); end
        1: begin
          if (m_q == m_tc) begin
            m_done = 1;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
            m_q = 0;
`else
            m_mode = 3;
`endif
          end else if (pause) m_mode = 2;
          else m_q = (m_q + 1) % (1 << W);
        end
        2: if (start) m_mode = 1;
        default: if (start) begin m_mode = 1; m_q = 0; m_tc = int'(tc_val); end
      endcase
    end
  endtask

  // Drive inputs, advance one clock, update the model, settle.
  task automatic cyc(input logic st, input logic pa, input logic cl, input logic rs,
                     input logic [W-1:0] tv);
    start = st; pause = pa; clear = cl; rst = rs; tc_val = tv;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle1();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q", int'(q), m_q);
      check("model_state", int'(state), m_mode);
      check("model_done", int'(done), m_done);
      check("model_busy", int'(busy), int'(m_mode == 1));
      check("model_paused", int'(paused), int'(m_mode == 2));
    end
  end

  int dcnt;

  initial begin
    start = 0; pause = 0; clear = 0; rst = 1; tc_val = 0;
    m_mode = 0; m_q = 0; m_tc = 0; m_done = 0;

    // Reset held two cycles with start asserted.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    check("rst_q", int'(q), 0);
    check("rst_state", int'(state), 0);
    check("rst_done", int'(done), 0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    check("rst2_q", int'(q), 0);
    check("rst2_state", int'(state), 0);
    check("rst2_done", int'(done), 0);

`ifndef CNT_SEQ_AUTO_RELOAD_EN
    // tc=5 one-shot.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    check("t2_busy", int'(busy), 1);
    check("t2_q0", int'(q), 0);
    for (int i = 1; i <= 5; i++) begin
      idle1();
      check("t2_q", int'(q), i);
      check("t2_nodone", int'(done), 0);
    end
    idle1();
    check("t2_done", int'(done), 1);
    check("t2_state", int'(state), 3);
    check("t2_qhold", int'(q), 5);
    idle1();
    check("t2_done_pulse", int'(done), 0);
    check("t2_qhold2", int'(q), 5);

    // tc=9 with a pause at q=3, then resume.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    check("t3_restart_q", int'(q), 0);
    for (int i = 0; i < 3; i++) idle1();
    check("t3_q3", int'(q), 3);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      check("t3_paused", int'(paused), 1);
      check("t3_frozen", int'(q), 3);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    check("t3_resume_state", int'(state), 1);
    check("t3_resume_q", int'(q), 3);
    for (int i = 4; i <= 9; i++) begin
      idle1();
      check("t3_q", int'(q), i);
      dcnt += int'(done);
    end
    idle1();
    dcnt += int'(done);
    check("t3_state", int'(state), 3);
    idle1();
    dcnt += int'(done);
    check("t3_done_count", dcnt, 1);
    check("t3_tc_kept", int'(q), 9);

    // tc=0 then tc=15.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t4_run", int'(state), 1);
    idle1();
    check("t4_tc0_done", int'(done), 1);
    check("t4_tc0_state", int'(state), 3);
    idle1();
    check("t4_tc0_single", int'(done), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
    for (int i = 1; i <= 15; i++) begin
      idle1();
      check("t4_q15", int'(q), i);
    end
    check("t4_nowrap_state", int'(state), 1);
    idle1();
    check("t4_tc15_state", int'(state), 3);
    check("t4_tc15_q", int'(q), 15);

    // clear in RUN at q=6, then clear with start.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 6; i++) idle1();
    check("t5_q6", int'(q), 6);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    check("t5_clr_state", int'(state), 0);
    check("t5_clr_q", int'(q), 0);
    check("t5_clr_done", int'(done), 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
    check("t5_clr_wins", int'(state), 0);
`else
    // Auto reload with tc=3: q cycles 0..3 and done pulses on each wrap.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    dcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      idle1();
      check("ar_q", int'(q), i % 4);
      check("ar_state", int'(state), 1);
      check("ar_done", int'(done), int'(i % 4 == 0));
      dcnt += int'(done);
    end
    check("ar_done_count", dcnt, 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
`endif

    // Randomized control traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic r_st, r_pa, r_cl, r_rs;
      r_st = ($urandom_range(0, 99) < 15);
      r_pa = ($urandom_range(0, 99) < 10);
      r_cl = ($urandom_range(0, 99) < 2);
      r_rs = ($urandom_range(0, 999) < 5);
      cyc(r_st, r_pa, r_cl, r_rs, W'($urandom_range(0, (1 << W) - 1)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
